// File: rtl/regfile_dump_if.sv
// regfile_dump_if: read/write/dump signal bundle for regfile_dump
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra, rb, rw, dump_addr;
  logic [DATA_W-1:0] busA, busB, busW, dump_data;
  logic              RegWr, dump_start, dump_ready;
  logic              dump_busy, dump_valid, dump_last;
  modport master (
    output ra, rb, rw, busW, RegWr, dump_start, dump_ready,
    input  busA, busB, dump_busy, dump_valid, dump_addr, dump_data, dump_last
  );
  modport slave (
    input  ra, rb, rw, busW, RegWr, dump_start, dump_ready,
    output busA, busB, dump_busy, dump_valid, dump_addr, dump_data, dump_last
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: register file with hardwired r0, two combinational read ports,
// one write port and a handshaked dump stream. Define REGFILE_BYPASS_EN to
// forward same-cycle write data to the read ports.
module regfile_dump #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 5,
  parameter int              REGNUM    = 32,
  parameter logic [DATA_W-1:0] REG0_DATA = '0
) (
  input logic           CLK,
  input logic           RST,
  regfile_dump_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(REGNUM);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REGNUM-1);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic              wen;
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return (a == '0) ? REG0_DATA : ({1'b0, a} < LIM) ? regs[a] : '0;
  endfunction
  assign wen = bus.RegWr && (bus.rw != '0) && ({1'b0, bus.rw} < LIM);
`ifdef REGFILE_BYPASS_EN
  assign bus.busA = (wen && bus.rw == bus.ra) ? bus.busW : rd(bus.ra);
  assign bus.busB = (wen && bus.rw == bus.rb) ? bus.busW : rd(bus.rb);
`else
  assign bus.busA = rd(bus.ra);
  assign bus.busB = rd(bus.rb);
`endif
  // register array: cleared by reset, written only at implemented nonzero indices
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[bus.rw] <= bus.busW;
    end
  end
  // dump state and beat index
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end
  // dump next state and beat outputs; data is read unbypassed so it tracks stalls
  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    bus.dump_valid = state == STREAM;
    bus.dump_busy  = state == STREAM;
    bus.dump_addr  = (state == STREAM) ? idx : '0;
    bus.dump_last  = (state == STREAM) && (idx == LAST);
    bus.dump_data  = rd(idx);
    if (state == IDLE && bus.dump_start) begin
      state_nx = STREAM;
      idx_nx   = '0;
    end else if (state == STREAM && bus.dump_ready) begin
      state_nx = (idx == LAST) ? IDLE : STREAM;
      idx_nx   = (idx == LAST) ? idx : idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed checks of regfile_dump (REGNUM=8, REG0_DATA=1)
module tb_regfile_dump;
  logic CLK = 0;
  logic RST = 1;
  int   pass = 0;
  int   total = 0;
  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_dump #(.DATA_W(32), .ADDR_W(5), .REGNUM(8), .REG0_DATA(32'h1)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.RegWr = 1; bus.rw = a; bus.busW = d;
    tick();
    bus.RegWr = 0;
  endtask
  function automatic logic [31:0] exp_d(input int i, input bit w77);
    return (i == 0) ? 32'h1 : (i == 2 && w77) ? 32'h77 : 32'(i * 'h11);
  endfunction
  task automatic test_reset;
    bus.ra = 5; #2;
    total++; if (bus.dump_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.dump_valid); else pass++;
    total++; if (bus.dump_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.dump_busy); else pass++;
    total++; if (bus.dump_addr !== 5'd0) $display("FAIL rst_addr: got %0d expected 0", bus.dump_addr); else pass++;
    total++; if (bus.dump_last !== 1'b0) $display("FAIL rst_last: got %b expected 0", bus.dump_last); else pass++;
    total++; if (bus.busA !== 32'h0) $display("FAIL rst_busA: got %h expected 0", bus.busA); else pass++;
    tick();
    RST = 0;
    tick();
  endtask
  task automatic test_reset_mid;
    bus.ra = 5; bus.dump_ready = 0; bus.dump_start = 1;
    bus.RegWr = 1; bus.rw = 5; bus.busW = 32'hDEADBEEF;
    tick();
    bus.RegWr = 0; bus.dump_start = 0;
    total++; if (bus.busA !== 32'hDEADBEEF) $display("FAIL mid_pre_busA: got %h expected deadbeef", bus.busA); else pass++;
    total++; if (bus.dump_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected 1", bus.dump_valid); else pass++;
    RST = 1; #2;
    total++; if (bus.busA !== 32'h0) $display("FAIL mid_busA: got %h expected 0", bus.busA); else pass++;
    total++; if (bus.dump_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", bus.dump_valid); else pass++;
    RST = 0;
    tick();
  endtask
  task automatic test_r0_range;
    wr(5'd0, 32'h1234);
    wr(5'd9, 32'hFFFF);
    bus.ra = 0; bus.rb = 9; #1;
    total++; if (bus.busA !== 32'h1) $display("FAIL r0_read: got %h expected 1", bus.busA); else pass++;
    total++; if (bus.busB !== 32'h0) $display("FAIL r9_read: got %h expected 0", bus.busB); else pass++;
  endtask
  task automatic test_write_read;
    logic [31:0] e;
`ifdef REGFILE_BYPASS_EN
    e = 32'hA5A5A5A5;
`else
    e = 32'h0;
`endif
    bus.ra = 3; bus.RegWr = 1; bus.rw = 3; bus.busW = 32'hA5A5A5A5; #1;
    total++; if (bus.busA !== e) $display("FAIL wr_same_cycle: got %h expected %h", bus.busA, e); else pass++;
    tick();
    bus.RegWr = 0;
    total++; if (bus.busA !== 32'hA5A5A5A5) $display("FAIL wr_next_cycle: got %h expected a5a5a5a5", bus.busA); else pass++;
  endtask
  task automatic test_full_dump;
    for (int i = 1; i < 8; i++) wr(5'(i), 32'(i * 'h11));
    bus.dump_ready = 1; bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.dump_valid !== 1'b1 || bus.dump_addr !== 5'(i) || bus.dump_data !== exp_d(i, 0) || bus.dump_last !== (i == 7))
        $display("FAIL dump_beat%0d: got v=%b a=%0d d=%h l=%b expected v=1 a=%0d d=%h l=%b", i, bus.dump_valid, bus.dump_addr, bus.dump_data, bus.dump_last, i, exp_d(i, 0), i == 7);
      else pass++;
      tick();
    end
    total++; if (bus.dump_busy !== 1'b0 || bus.dump_valid !== 1'b0) $display("FAIL dump_end: got busy=%b valid=%b expected 0 0", bus.dump_busy, bus.dump_valid); else pass++;
  endtask
  task automatic test_backpressure;
    bit rdy [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    int e = 0;
    bit w77 = 0;
    bus.dump_ready = 1; bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    for (int c = 0; c < 10; c++) begin
      bus.dump_ready = rdy[c];
      if (c == 2) begin bus.RegWr = 1; bus.rw = 2; bus.busW = 32'h77; end
      #1;
      total++; if (bus.dump_valid !== 1'b1 || bus.dump_addr !== 5'(e) || bus.dump_data !== exp_d(e, w77))
        $display("FAIL bp_cycle%0d: got v=%b a=%0d d=%h expected v=1 a=%0d d=%h", c, bus.dump_valid, bus.dump_addr, bus.dump_data, e, exp_d(e, w77));
      else pass++;
      tick();
      bus.RegWr = 0;
      if (c == 2) w77 = 1;
      if (rdy[c]) e++;
    end
    total++; if (bus.dump_busy !== 1'b0) $display("FAIL bp_end_busy: got %b expected 0", bus.dump_busy); else pass++;
  endtask
  task automatic test_restart_abort;
    int n = 0;
    bus.dump_ready = 1; bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    tick();
    bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    total++; if (bus.dump_addr !== 5'd2) $display("FAIL restart_ignored: got addr %0d expected 2", bus.dump_addr); else pass++;
    tick(); tick();
    total++; if (bus.dump_addr !== 5'd4) $display("FAIL abort_at4: got addr %0d expected 4", bus.dump_addr); else pass++;
    RST = 1; #2;
    total++; if (bus.dump_valid !== 1'b0) $display("FAIL abort_valid: got %b expected 0", bus.dump_valid); else pass++;
    RST = 0;
    tick(); tick();
    total++; if (bus.dump_valid !== 1'b0 || bus.dump_busy !== 1'b0) $display("FAIL abort_stays: got v=%b busy=%b expected 0 0", bus.dump_valid, bus.dump_busy); else pass++;
    bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    total++; if (bus.dump_valid !== 1'b1 || bus.dump_addr !== 5'd0 || bus.dump_data !== 32'h1)
      $display("FAIL restart_beat0: got v=%b a=%0d d=%h expected v=1 a=0 d=1", bus.dump_valid, bus.dump_addr, bus.dump_data);
    else pass++;
    tick();
    total++; if (bus.dump_addr !== 5'd1 || bus.dump_data !== 32'h0) $display("FAIL restart_beat1: got a=%0d d=%h expected a=1 d=0", bus.dump_addr, bus.dump_data); else pass++;
    while (bus.dump_busy && n < 20) begin tick(); n++; end
    total++; if (bus.dump_busy !== 1'b0) $display("FAIL restart_drain: got busy=%b expected 0 within 20 cycles", bus.dump_busy); else pass++;
  endtask
  initial begin
    bus.ra = 0; bus.rb = 0; bus.rw = 0; bus.busW = 0; bus.RegWr = 0;
    bus.dump_start = 0; bus.dump_ready = 0;
    test_reset();
    test_reset_mid();
    test_r0_range();
    test_write_read();
    test_full_dump();
    test_backpressure();
    test_restart_abort();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Parametrised general-purpose register file for the single-cycle nanoMIPS core. It provides two combinational read ports, one clocked write port, and a hardwired register 0. A handshake-driven dump port streams every register out in index order for the hardware-test harness. An asynchronous reset clears the whole array.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- REGNUM, 32, number of implemented registers; legal range 2..2^ADDR_W
- REG0_DATA, 0, constant value always read from register 0

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- ra  in  ADDR_W  read address A
- rb  in  ADDR_W  read address B
- busA  out  DATA_W  read data A
- busB  out  DATA_W  read data B
- rw  in  ADDR_W  write address
- busW  in  DATA_W  write data
- RegWr  in  1  write enable
- dump_start  in  1  request a full register dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump_addr/dump_data valid
- dump_ready  in  1  sink accepts current dump beat
- dump_addr  out  ADDR_W  index of current beat
- dump_data  out  DATA_W  value of register dump_addr
- dump_last  out  1  current beat is index REGNUM-1

## Operation
- Reset (RST=1, asynchronous): all registers clear to 0; dump FSM goes to IDLE; dump_busy=0, dump_valid=0, dump_addr=0, dump_last=0.
- Read: busA = REG0_DATA if ra==0; 0 if ra>=REGNUM; otherwise regs[ra]. The same rules apply to busB with rb.
- Write: at a rising edge with RegWr=1, 0<rw<REGNUM: regs[rw] <= busW. A write with rw==0 or rw>=REGNUM is dropped silently.
- Dump FSM, two states:
  - IDLE: dump_valid=0, dump_busy=0. If dump_start=1 at an edge: index <= 0 and the FSM goes to STREAM.
  - STREAM: dump_valid=1, dump_busy=1, dump_addr=index, dump_last=(index==REGNUM-1). dump_data follows the read rules (index 0 gives REG0_DATA) and shows the stored value, with no bypass.
  - A beat transfers when dump_valid and dump_ready are both 1 at an edge. On a non-last beat, index increments. On the last beat, the FSM returns to IDLE.
  - While dump_ready=0, addr, data and last hold. The exception is dump_data, which tracks a register written during the stall.
- dump_start is ignored in STREAM. The dump never blocks normal reads or writes.
- A write to regs[index] at the transfer edge is not in that beat; the sink receives the pre-edge value.
- RST asserted mid-dump aborts the stream immediately; no further beats are sent.

## Timing
- Reads are combinational, zero latency.
- A write becomes visible on busA/busB the cycle after the edge (base build).
- dump_start sampled at edge N gives dump_valid=1 from edge N onward.
- With dump_ready held at 1, REGNUM beats take REGNUM consecutive cycles. dump_busy falls at the edge of the last transfer.
- A new dump_start is accepted at the first edge with the FSM in IDLE, i.e. one cycle after the last beat.
- RST deassertion is synchronised externally; there is no internal requirement beyond standard recovery/removal.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding. If RegWr=1, rw==ra, rw!=0 and rw<REGNUM, then busA=busW in the same cycle; busB behaves the same with rb. The dump port is never bypassed.
- REGFILE_BYPASS_EN undefined: no forwarding; a read in the write cycle returns the old value.

## Test plan
- Reset mid-operation: write 0xDEADBEEF to r5, pulse RST for half a cycle with no clock edge. Required: ra=5 reads 0; dump_valid=0 immediately.
- r0 and range: REG0_DATA=1, write 0x1234 to r0. Required: ra=0 reads 1. With REGNUM=8, ADDR_W=5, writing r9 is dropped and rb=9 reads 0.
- Write/read: write 0xA5A5A5A5 to r3. Required: busA (ra=3) reads the new value the cycle after the edge. In the same cycle it reads the old value 0 without REGFILE_BYPASS_EN and 0xA5A5A5A5 with it.
- Full dump, ready=1: regs[i]=i*0x11, pulse dump_start. Required: REGNUM consecutive beats, addr 0..REGNUM-1, data REG0_DATA then 0x11, 0x22, …; dump_last only on the final beat; busy low the cycle after.
- Backpressure: toggle dump_ready 1,0,0,1 across the stream, and write r2=0x77 while beat 2 is stalled. Required: no beat lost or duplicated, and beat 2 carries 0x77.
- Restart and abort: assert dump_start during STREAM (ignored), then assert RST at beat 4. Required: the stream stops; a new dump_start afterwards restarts from addr 0.
